// File: rtl/rv_pkg.sv
// Shared RV64I decode definitions: ALU op codes, major opcodes, decoded control bundle
// and the immediate generator used by the decoder.
package rv_pkg;

    localparam int RV_XLEN    = 64;
    localparam int RV_ALUOP_W = 4;

    // Branches use 12 + funct3[2:1]; code 13 is never produced (funct3 010/011 are illegal).
    typedef enum logic [RV_ALUOP_W-1:0] {
        ALUOP_NOP     = 4'd0,
        ALUOP_ADD     = 4'd1,
        ALUOP_SUB     = 4'd2,
        ALUOP_SLL     = 4'd3,
        ALUOP_SLT     = 4'd4,
        ALUOP_SLTU    = 4'd5,
        ALUOP_XOR     = 4'd6,
        ALUOP_SRL     = 4'd7,
        ALUOP_SRA     = 4'd8,
        ALUOP_OR      = 4'd9,
        ALUOP_AND     = 4'd10,
        ALUOP_PASSB   = 4'd11,
        ALUOP_CMP_EQ  = 4'd12,
        ALUOP_CMP_RSV = 4'd13,
        ALUOP_CMP_LT  = 4'd14,
        ALUOP_CMP_LTU = 4'd15
    } rv_aluop_e;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } rv_fmt_e;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;

    typedef struct packed {
        rv_aluop_e  alu_op;
        logic       use_imm;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       word_op;
        logic       illegal;
    } rv_ctrl_t;

    localparam int RV_CTRL_W = $bits(rv_ctrl_t);

    // Register-register / register-immediate ALU op selected by funct3.
    function automatic rv_aluop_e alu_from_f3(input logic [2:0] f3);
        rv_aluop_e op;
        case (f3)
            3'b000:  op = ALUOP_ADD;
            3'b001:  op = ALUOP_SLL;
            3'b010:  op = ALUOP_SLT;
            3'b011:  op = ALUOP_SLTU;
            3'b100:  op = ALUOP_XOR;
            3'b101:  op = ALUOP_SRL;
            3'b110:  op = ALUOP_OR;
            default: op = ALUOP_AND;
        endcase
        return op;
    endfunction

    // Every RV immediate fits in 32 bits sign-extended from instr[31]; callers widen to XLEN.
    function automatic logic [31:0] imm32(input rv_fmt_e fmt, input logic [31:0] ins);
        logic [31:0] v;
        case (fmt)
            FMT_I:   v = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   v = {ins[31:12], 12'b0};
            FMT_J:   v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Pure combinational RV64I instruction decoder: raw instruction -> control bundle + immediate.
module rv_decode_comb
    import rv_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter bit SUPPORT_W = 1'b1
) (
    input  logic [31:0]     instr_i,
    output rv_ctrl_t        ctrl_o,
    output logic [XLEN-1:0] imm_o
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    logic        wr_rd;
    rv_fmt_e     fmt;
    logic [31:0] imm_w;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    always_comb begin
        ctrl_o     = '0;
        ctrl_o.rd  = instr_i[11:7];
        ctrl_o.rs1 = instr_i[19:15];
        ctrl_o.rs2 = instr_i[24:20];
        legal      = 1'b1;
        wr_rd      = 1'b0;
        fmt        = FMT_R;

        case (opcode)
            OPC_OP: begin
                wr_rd = 1'b1;
                if (f7 == 7'b0000000) begin
                    ctrl_o.alu_op = alu_from_f3(f3);
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    ctrl_o.alu_op = ALUOP_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    ctrl_o.alu_op = ALUOP_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                wr_rd          = 1'b1;
                fmt            = FMT_I;
                ctrl_o.use_imm = 1'b1;
                ctrl_o.alu_op  = alu_from_f3(f3);
                // RV64 shifts carry a 6-bit shamt, so only imm[11:6] is the function field.
                if (f3 == 3'b001) begin
                    legal = (instr_i[31:26] == 6'b000000);
                end else if (f3 == 3'b101) begin
                    if (instr_i[31:26] == 6'b010000) begin
                        ctrl_o.alu_op = ALUOP_SRA;
                    end else begin
                        legal = (instr_i[31:26] == 6'b000000);
                    end
                end
            end
            OPC_OP_32: begin
                wr_rd          = 1'b1;
                ctrl_o.word_op = 1'b1;
                if (!SUPPORT_W) begin
                    legal = 1'b0;
                end else if (f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) begin
                    ctrl_o.alu_op = alu_from_f3(f3);
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    ctrl_o.alu_op = ALUOP_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    ctrl_o.alu_op = ALUOP_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM_32: begin
                wr_rd          = 1'b1;
                fmt            = FMT_I;
                ctrl_o.use_imm = 1'b1;
                ctrl_o.word_op = 1'b1;
                if (!SUPPORT_W) begin
                    legal = 1'b0;
                end else if (f3 == 3'b000) begin
                    ctrl_o.alu_op = ALUOP_ADD;
                end else if (f3 == 3'b001 && f7 == 7'b0000000) begin
                    ctrl_o.alu_op = ALUOP_SLL;
                end else if (f3 == 3'b101 && f7 == 7'b0000000) begin
                    ctrl_o.alu_op = ALUOP_SRL;
                end else if (f3 == 3'b101 && f7 == 7'b0100000) begin
                    ctrl_o.alu_op = ALUOP_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_LOAD: begin
                wr_rd           = 1'b1;
                fmt             = FMT_I;
                ctrl_o.use_imm  = 1'b1;
                ctrl_o.alu_op   = ALUOP_ADD;
                ctrl_o.mem_read = 1'b1;
                legal           = (f3 != 3'b111);
            end
            OPC_STORE: begin
                fmt              = FMT_S;
                ctrl_o.use_imm   = 1'b1;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.mem_write = 1'b1;
                legal            = !f3[2];
            end
            OPC_BRANCH: begin
                fmt           = FMT_B;
                ctrl_o.branch = 1'b1;
                case (f3[2:1])
                    2'b00:   ctrl_o.alu_op = ALUOP_CMP_EQ;
                    2'b10:   ctrl_o.alu_op = ALUOP_CMP_LT;
                    2'b11:   ctrl_o.alu_op = ALUOP_CMP_LTU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                wr_rd          = 1'b1;
                fmt            = FMT_U;
                ctrl_o.use_imm = 1'b1;
                ctrl_o.alu_op  = ALUOP_PASSB;
            end
            OPC_AUIPC: begin
                wr_rd          = 1'b1;
                fmt            = FMT_U;
                ctrl_o.use_imm = 1'b1;
                ctrl_o.alu_op  = ALUOP_ADD;
            end
            OPC_JAL: begin
                wr_rd          = 1'b1;
                fmt            = FMT_J;
                ctrl_o.use_imm = 1'b1;
                ctrl_o.alu_op  = ALUOP_ADD;
                ctrl_o.jump    = 1'b1;
            end
            OPC_JALR: begin
                wr_rd          = 1'b1;
                fmt            = FMT_I;
                ctrl_o.use_imm = 1'b1;
                ctrl_o.alu_op  = ALUOP_ADD;
                ctrl_o.jump    = 1'b1;
                legal          = (f3 == 3'b000);
            end
            default: legal = 1'b0;
        endcase

        // Illegal bundles keep their register fields but carry no operation or side effect.
        if (!legal) begin
            ctrl_o.alu_op    = ALUOP_NOP;
            ctrl_o.use_imm   = 1'b0;
            ctrl_o.mem_read  = 1'b0;
            ctrl_o.mem_write = 1'b0;
            ctrl_o.branch    = 1'b0;
            ctrl_o.jump      = 1'b0;
            ctrl_o.word_op   = 1'b0;
            ctrl_o.illegal   = 1'b1;
            fmt              = FMT_R;
        end
        ctrl_o.reg_write = wr_rd && legal && (instr_i[11:7] != 5'd0);
    end

    assign imm_w = imm32(fmt, instr_i);
    assign imm_o = {{(XLEN-32){imm_w[31]}}, imm_w};

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV64I decode stage with a two-entry skid buffer (output entry E0, skid entry E1)
// so that in_ready comes straight from a flop.
module rv_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN      = RV_XLEN,
    parameter int ALUOP_W   = RV_ALUOP_W,
    parameter bit SUPPORT_W = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               use_imm,
    output logic [XLEN-1:0]    imm,
    output logic [4:0]         rd,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               branch,
    output logic               jump,
    output logic               word_op,
    output logic               illegal
);

    typedef struct packed {
        rv_ctrl_t        ctrl;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } entry_t;

    rv_ctrl_t        dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    entry_t          new_entry;
    entry_t          e0_q, e0_d, e1_q, e1_d;
    logic            e0_vld_q, e0_vld_d, e1_vld_q, e1_vld_d;
    logic            push, pop;

    rv_decode_comb #(
        .XLEN      (XLEN),
        .SUPPORT_W (SUPPORT_W)
    ) u_decode (
        .instr_i (in_instr),
        .ctrl_o  (dec_ctrl),
        .imm_o   (dec_imm)
    );

    assign new_entry = '{ctrl: dec_ctrl, imm: dec_imm, pc: in_pc};
    assign in_ready  = !e1_vld_q;
    assign push      = in_valid && in_ready;
    assign pop       = e0_vld_q && out_ready;

    always_comb begin
        e0_d     = e0_q;
        e1_d     = e1_q;
        e0_vld_d = e0_vld_q;
        e1_vld_d = e1_vld_q;
        if (flush) begin
            e0_vld_d = 1'b0;
            e1_vld_d = 1'b0;
        end else if (e1_vld_q) begin
            // Skid full: input is stalled, only a pop can move things forward.
            if (pop) begin
                e0_d     = e1_q;
                e1_vld_d = 1'b0;
            end
        end else if (e0_vld_q) begin
            if (pop && push) begin
                e0_d = new_entry;
            end else if (pop) begin
                e0_vld_d = 1'b0;
            end else if (push) begin
                e1_d     = new_entry;
                e1_vld_d = 1'b1;
            end
        end else if (push) begin
            e0_d     = new_entry;
            e0_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q     <= '0;
            e1_q     <= '0;
            e0_vld_q <= 1'b0;
            e1_vld_q <= 1'b0;
        end else begin
            e0_q     <= e0_d;
            e1_q     <= e1_d;
            e0_vld_q <= e0_vld_d;
            e1_vld_q <= e1_vld_d;
        end
    end

    assign out_valid = e0_vld_q;
    assign out_pc    = e0_q.pc;
    assign alu_op    = ALUOP_W'(e0_q.ctrl.alu_op);
    assign use_imm   = e0_q.ctrl.use_imm;
    assign imm       = e0_q.imm;
    assign rd        = e0_q.ctrl.rd;
    assign rs1       = e0_q.ctrl.rs1;
    assign rs2       = e0_q.ctrl.rs2;
    assign reg_write = e0_q.ctrl.reg_write;
    assign mem_read  = e0_q.ctrl.mem_read;
    assign mem_write = e0_q.ctrl.mem_write;
    assign branch    = e0_q.ctrl.branch;
    assign jump      = e0_q.ctrl.jump;
    assign word_op   = e0_q.ctrl.word_op;
    assign illegal   = e0_q.ctrl.illegal;

endmodule
